// File: rtl/hci_router_reorder_stall.sv
`default_nettype none
// ============================================================================
// Module   : hci_router_reorder_stall
// Purpose  : Broadcast router from one multi-channel HCI initiator onto
//            NB_OUT_CHAN TCDM banks. The shared request is rotated by a start
//            offset. Per-bank grant stalls are absorbed: only banks not yet
//            granted are re-requested, early bank responses are buffered, and
//            the initiator sees one all-channel grant plus one aligned
//            response the cycle after the final bank grant.
// Ports    : clk_i, rst_i (sync, active-high), clear_i (sync soft clear)
//            order_i          rotation offset (sampled at transaction start)
//            in_*_i / in_*_o  initiator channels (req/gnt/add/wen/be/data,
//                             r_data/r_valid), flattened per channel
//            out_*_o/out_*_i  bank ports, flattened per bank
//            stall_cnt_o      saturating count of stalled request cycles
// Revision : 1.0 - initial release
// ============================================================================
module hci_router_reorder_stall #(
  parameter int NB_IN_CHAN           = 2,
  parameter int NB_OUT_CHAN          = 2,
  parameter int DW                   = 32,
  parameter int AW                   = 32,
  parameter bit FILTER_WRITE_R_VALID = 1'b0,
  localparam int OW = (NB_OUT_CHAN > 1) ? $clog2(NB_OUT_CHAN) : 1,
  localparam int BW = DW / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic [OW-1:0]                  order_i,
  // initiator side
  input  logic [NB_IN_CHAN-1:0]          in_req_i,
  output logic [NB_IN_CHAN-1:0]          in_gnt_o,
  input  logic [NB_IN_CHAN-1:0][AW-1:0]  in_add_i,
  input  logic [NB_IN_CHAN-1:0]          in_wen_i,
  input  logic [NB_IN_CHAN-1:0][BW-1:0]  in_be_i,
  input  logic [NB_IN_CHAN-1:0][DW-1:0]  in_data_i,
  output logic [NB_IN_CHAN-1:0][DW-1:0]  in_r_data_o,
  output logic [NB_IN_CHAN-1:0]          in_r_valid_o,
  // bank side
  output logic [NB_OUT_CHAN-1:0]         out_req_o,
  input  logic [NB_OUT_CHAN-1:0]         out_gnt_i,
  output logic [NB_OUT_CHAN-1:0][AW-1:0] out_add_o,
  output logic [NB_OUT_CHAN-1:0]         out_wen_o,
  output logic [NB_OUT_CHAN-1:0][BW-1:0] out_be_o,
  output logic [NB_OUT_CHAN-1:0][DW-1:0] out_data_o,
  input  logic [NB_OUT_CHAN-1:0][DW-1:0] out_r_data_i,
  input  logic [NB_OUT_CHAN-1:0]         out_r_valid_i,
  // profiling
  output logic [31:0]                    stall_cnt_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                          busy_q, busy_d;
  logic [OW-1:0]                 order_q, order_d;
  logic [OW-1:0]                 ordr_q;       // offset in force last cycle
  logic [NB_OUT_CHAN-1:0]        granted_q, granted_d;
  logic [NB_OUT_CHAN-1:0]        newgnt_q;
  logic [NB_OUT_CHAN-1:0]        fin_q, fin_d;
  logic                          rv_q, rv_d;
  logic [NB_IN_CHAN-1:0][DW-1:0] resp_q, resp_d;
  logic [31:0]                   stall_q, stall_d;

  logic [OW-1:0]                 w_ord;
  logic [OW:0]                   w_order_ext;
  logic [NB_OUT_CHAN-1:0]        w_newgnt;
  logic                          w_all_done;
  logic                          w_gnt;
  logic                          w_unused;

  // Bank serving channel ch under rotation ord. ch < NB_OUT_CHAN and
  // ord < NB_OUT_CHAN, so a single conditional subtract is a full modulo.
  function automatic int bank_of(input int ch, input logic [OW-1:0] ord);
    int s;
    s = ch + int'(ord);
    if (s >= NB_OUT_CHAN) s = s - NB_OUT_CHAN;
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Rotation offset: latched value while busy, otherwise order_i reduced
  // modulo NB_OUT_CHAN (order_i < 2*NB_OUT_CHAN, so one subtract suffices).
  // --------------------------------------------------------------------------
  assign w_order_ext = {1'b0, order_i};

  always_comb begin
    if (busy_q) begin
      w_ord = order_q;
    end else if (w_order_ext >= (OW+1)'(NB_OUT_CHAN)) begin
      w_ord = OW'(w_order_ext - (OW+1)'(NB_OUT_CHAN));
    end else begin
      w_ord = order_i;
    end
  end

  // --------------------------------------------------------------------------
  // Request fan-out. Already-granted banks drop their request so that each
  // bank is asked exactly once per transaction. A bank is done when it was
  // granted earlier or is granted now; the request qualification is folded
  // into w_gnt below.
  // --------------------------------------------------------------------------
  always_comb begin
    out_req_o  = '0;
    out_add_o  = '0;
    out_be_o   = '0;
    out_data_o = '0;
    w_all_done = 1'b1;
    for (int b = 0; b < NB_OUT_CHAN; b++) begin
      for (int i = 0; i < NB_IN_CHAN; i++) begin
        if (bank_of(i, w_ord) == b) begin
          out_req_o[b]  = in_req_i[0] & ~granted_q[b];
          out_add_o[b]  = in_add_i[i];
          out_be_o[b]   = in_be_i[i];
          out_data_o[b] = in_data_i[i];
          w_all_done    = w_all_done & (granted_q[b] | out_gnt_i[b]);
        end
      end
    end
  end

  assign out_wen_o = {NB_OUT_CHAN{in_wen_i[0]}};
  assign w_newgnt  = out_req_o & out_gnt_i;
  assign w_gnt     = in_req_i[0] & w_all_done;
  assign in_gnt_o  = {NB_IN_CHAN{w_gnt}};

  // --------------------------------------------------------------------------
  // Response path. Banks answer one cycle after their own grant; ordr_q is
  // the offset of that grant cycle, so it maps a bank back to its channel.
  // Banks granted in the final cycle answer live in the response cycle
  // (fin_q); earlier ones were parked in resp_q.
  // --------------------------------------------------------------------------
  always_comb begin
    resp_d = resp_q;
    for (int b = 0; b < NB_OUT_CHAN; b++) begin
      for (int i = 0; i < NB_IN_CHAN; i++) begin
        if (newgnt_q[b] && (bank_of(i, ordr_q) == b)) begin
          resp_d[i] = out_r_data_i[b];
        end
      end
    end
  end

  always_comb begin
    in_r_data_o = resp_q;
    for (int b = 0; b < NB_OUT_CHAN; b++) begin
      for (int i = 0; i < NB_IN_CHAN; i++) begin
        if (fin_q[b] && (bank_of(i, ordr_q) == b)) begin
          in_r_data_o[i] = out_r_data_i[b];
        end
      end
    end
  end

  assign in_r_valid_o = {NB_IN_CHAN{rv_q}};
  assign stall_cnt_o  = stall_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d    = busy_q;
    order_d   = order_q;
    granted_d = granted_q;
    if (w_gnt) begin
      busy_d    = 1'b0;
      granted_d = '0;
    end else if (in_req_i[0]) begin
      busy_d    = 1'b1;
      granted_d = granted_q | w_newgnt;
      if (!busy_q) order_d = w_ord;
    end
    fin_d   = w_gnt ? w_newgnt : '0;
    rv_d    = w_gnt & (FILTER_WRITE_R_VALID ? in_wen_i[0] : 1'b1);
    stall_d = stall_q;
    if (in_req_i[0] && !w_gnt && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      busy_q    <= 1'b0;
      order_q   <= '0;
      ordr_q    <= '0;
      granted_q <= '0;
      newgnt_q  <= '0;
      fin_q     <= '0;
      rv_q      <= 1'b0;
      resp_q    <= '0;
      stall_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      order_q   <= order_d;
      ordr_q    <= w_ord;
      granted_q <= granted_d;
      newgnt_q  <= w_newgnt;
      fin_q     <= fin_d;
      rv_q      <= rv_d;
      resp_q    <= resp_d;
      stall_q   <= stall_d;
    end
  end

  // Only channel 0 carries req/wen, and bank r_valid is not needed because
  // bank latency is fixed.
  assign w_unused = ^{in_req_i, in_wen_i, out_r_valid_i};

endmodule
`default_nettype wire

// File: doc/hci_router_reorder_stall.md
# hci_router_reorder_stall

Parametrised successor of the rotated broadcast router between a multi-channel HCI initiator (streamer/accelerator port) and NB_OUT_CHAN TCDM banks. One shared request is rotated onto banks by a start offset, as before. The block also tolerates per-bank grant stalls: it keeps re-requesting only the banks not yet granted, buffers early responses, and returns one all-channel grant and one aligned response one cycle after the final grant. Widths are generic, and a saturating stall counter supports profiling.

## Interface
- NB_IN_CHAN, 2: initiator channels; must be ≤ NB_OUT_CHAN.
- NB_OUT_CHAN, 2: bank ports; need not be a power of two.
- DW, 32: data width; byte-enable width is DW/8.
- AW, 32: address width.
- FILTER_WRITE_R_VALID, 0: 1 suppresses r_valid for writes.
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous soft clear; identical effect to rst_i.
- order_i  in  max(1,$clog2(NB_OUT_CHAN))  rotation offset.
- in  hwpe_stream_intf_tcdm.target [NB_IN_CHAN]  initiator channels: req, gnt, add, wen (1 = read), be, data, r_data, r_valid.
- out  hwpe_stream_intf_tcdm.initiator [NB_OUT_CHAN]  bank ports. Bank r_valid is ignored; banks have a fixed read latency of 1 after their own gnt.
- stall_cnt_o  out  32  saturating count of stalled request cycles.

## Operation
- Transaction request is in[0].req. in[0].wen applies to all channels. add/be/data are taken per channel. The initiator holds all request fields stable until gnt.
- Mapping: channel i goes to bank b(i) = (ord + i) mod NB_OUT_CHAN.
  - ord = busy_q ? order_q : (order_i mod NB_OUT_CHAN).
  - Unmapped banks see req = 0 and add/be/data = 0.
- Bank request: out[b(i)].req = in[0].req & ~granted_q[b(i)]. Each bank's wen is in[0].wen.
- bank_done[b] = granted_q[b] | (out[b].req & out[b].gnt).
- in gnt (all channels, combinational) = in[0].req & AND of bank_done over mapped banks.
- State update each cycle:
  - Request and no gnt: granted_q |= newly granted banks. busy_q ← 1. order_q ← ord when busy_q = 0.
  - Gnt: granted_q ← 0, busy_q ← 0.
- Response path:
  - newgnt_q[b] ← out[b].req & out[b].gnt, registered every cycle.
  - When newgnt_q[b] = 1, resp_q[channel of b] ← out[b].r_data.
  - fin_q[b] ← newgnt_q value of the in-gnt cycle.
- Response cycle (cycle after in gnt): in[i].r_data = fin_q[b(i)] ? live out[b(i)].r_data : resp_q[i]. The mapping used is the one latched with the transaction (ordr_q).
- in[i].r_valid = rv_q. rv_q ← in gnt & (FILTER_WRITE_R_VALID ? in[0].wen : 1).
- stall_cnt_o increments on every cycle with in[0].req & ~gnt. It saturates at 2^32−1 and is cleared only by rst_i/clear_i.
- Reset/clear, mid-transaction included:
  - Cleared: busy_q, granted_q, newgnt_q, fin_q, rv_q, resp_q, order_q, stall_cnt_o.
  - The pending transaction is dropped. If the initiator still holds req, the transaction restarts on the next cycle with all banks re-requested and order_i re-sampled.

## Timing
- Reset values: all in r_valid = 0, all in r_data = 0, stall_cnt_o = 0. out req, in gnt and out add/be/data follow inputs combinationally.
- No contention: gnt in the same cycle as req; r_valid/r_data at +1.
- Worst bank granted at cycle k after request start: in gnt at k, r_valid at k+1, stall_cnt_o += k.
- Early-granted banks are requested exactly once and never re-requested in the same transaction.
- Back-to-back: a new transaction may start the cycle after gnt. Its earliest bank response lands at gnt+2, so it never overwrites resp_q before the response cycle at gnt+1.
- order_i changes while busy_q = 1 are ignored.
- Simultaneous gnt and rst_i: reset wins; r_valid stays 0.

## Test plan
- NB_IN=4, NB_OUT=4, order_i=1, all bank gnt=1, read → banks 1,2,3,0 get channels 0..3 in cycle 0; in gnt in cycle 0; r_valid=1 in cycle 1 with in[i].r_data = bank((i+1)%4) data.
- Same setup, bank 2 gnt low for cycles 0–2 → banks 1,3,0 req only in cycle 0; bank 2 req in cycles 0–3; in gnt in cycle 3; r_valid in cycle 4 with channels 0,2,3 holding the data presented in cycle 1 and channel 1 the live data of cycle 4; stall_cnt_o=3.
- During the stall above, change order_i 1→3 in cycle 1 → mapping unchanged until gnt; the next transaction uses 3.
- NB_OUT=3 (non-power-of-two), NB_IN=2, order_i=2 → channels map to banks 2,0; bank 1 req=0 throughout.
- Write transaction: FILTER_WRITE_R_VALID=1 → no r_valid; =0 → r_valid=1 at gnt+1.
- rst_i in cycle 1 of a stalled transaction, req held → cycle 2 re-requests all mapped banks; stall_cnt_o=0 in cycle 2; no r_valid until the new gnt.
